// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter. Ownership changes only at transfer boundaries.
// Optional master locking is enabled with AHB_ARB_LOCK_EN.
module ahb_arbiter #(
  parameter int unsigned MASTERS = 4,
  parameter int unsigned OWNER_W = $clog2(MASTERS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [MASTERS-1:0] req,
  input  logic [1:0]         trans,
  input  logic [2:0]         burst,
  input  logic               ready,
`ifdef AHB_ARB_LOCK_EN
  input  logic [MASTERS-1:0] lock,
`endif
  output logic [MASTERS-1:0] grant,
  output logic [OWNER_W-1:0] addr_owner,
  output logic [OWNER_W-1:0] data_owner,
  output logic               data_valid
);

  localparam int M = int'(MASTERS);

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  localparam logic [2:0] BrSingle = 3'b000;
  localparam logic [2:0] BrIncr   = 3'b001;
  localparam logic [2:0] BrWrap4  = 3'b010;
  localparam logic [2:0] BrIncr4  = 3'b011;
  localparam logic [2:0] BrWrap8  = 3'b100;
  localparam logic [2:0] BrIncr8  = 3'b101;
  localparam logic [2:0] BrWrap16 = 3'b110;
  localparam logic [2:0] BrIncr16 = 3'b111;

  typedef enum logic [1:0] {StArb, StBurst, StUndef} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [MASTERS-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0]   downer_q;
  logic                 dvalid_q;

  logic                 is_idle, is_nonseq, is_seq;
  logic                 owner_req;
  logic                 rearb;
  logic                 hold_lock;
  logic [3:0]           beat_load;
  state_e               start_state;
  logic [OWNER_W-1:0]   rr_pick;

  assign is_idle   = (trans == TrIdle);
  assign is_nonseq = (trans == TrNonseq);
  assign is_seq    = (trans == TrSeq);
  assign owner_req = req[owner_q];

`ifdef AHB_ARB_LOCK_EN
  assign hold_lock = lock[owner_q];
`else
  assign hold_lock = 1'b0;
`endif

  // Beat count and follow-on state implied by the HBURST of a NONSEQ.
  always_comb begin
    beat_load   = 4'd0;
    start_state = StArb;
    unique case (burst)
      BrSingle: begin
        beat_load   = 4'd0;
        start_state = StArb;
      end
      BrIncr: begin
        beat_load   = 4'd0;
        start_state = StUndef;
      end
      BrWrap4, BrIncr4: begin
        beat_load   = 4'd3;
        start_state = StBurst;
      end
      BrWrap8, BrIncr8: begin
        beat_load   = 4'd7;
        start_state = StBurst;
      end
      BrWrap16, BrIncr16: begin
        beat_load   = 4'd15;
        start_state = StBurst;
      end
      default: begin
        beat_load   = 4'd0;
        start_state = StArb;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rearb   = 1'b0;
    if (ready) begin
      if (is_nonseq) begin
        cnt_d = beat_load;
      end else if (is_seq && (cnt_q != 4'd0)) begin
        cnt_d = cnt_q - 4'd1;
      end
      unique case (state_q)
        StArb: begin
          if (is_idle) begin
            rearb = 1'b1;
          end else if (is_nonseq) begin
            state_d = start_state;
            rearb   = (burst == BrSingle);
          end
        end
        StBurst: begin
          if (is_seq && (cnt_q == 4'd1)) begin
            state_d = StArb;
            rearb   = 1'b1;
          end else if (is_nonseq) begin
            state_d = start_state;
          end
        end
        StUndef: begin
          // Undefined-length burst ends on IDLE, or on a NONSEQ once the owner stops asking.
          if (is_idle || (is_nonseq && !owner_req)) begin
            state_d = StArb;
            rearb   = 1'b1;
          end else if (is_nonseq) begin
            state_d = start_state;
          end
        end
        default: state_d = StArb;
      endcase
    end
  end

  // Walk from the farthest candidate to the nearest so the nearest requester wins;
  // the current owner is only kept when nobody else asks.
  always_comb begin
    int idx;
    logic [OWNER_W-1:0] sel;
    idx     = 0;
    sel     = '0;
    rr_pick = owner_q;
    for (int i = M - 1; i >= 1; i--) begin
      idx = int'(owner_q) + i;
      if (idx >= M) idx = idx - M;
      sel = OWNER_W'(idx);
      if (req[sel]) rr_pick = sel;
    end
  end

  always_comb begin
    owner_d          = (rearb && !hold_lock) ? rr_pick : owner_q;
    grant_d          = '0;
    grant_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StArb;
      cnt_q    <= 4'd0;
      owner_q  <= '0;
      grant_q  <= MASTERS'(1);
      downer_q <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      if (ready) begin
        downer_q <= owner_q;
        dvalid_q <= trans[1];
      end
    end
  end

  assign grant      = grant_q;
  assign addr_owner = owner_q;
  assign data_owner = downer_q;
  assign data_valid = dvalid_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a transfer-level reference model.
module tb_ahb_arbiter;

  localparam int M = 4;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;
  logic [3:0] lock;
  logic [3:0] grant;
  logic [1:0] addr_owner;
  logic [1:0] data_owner;
  logic       data_valid;

  int total = 0;
  int bad   = 0;

  ahb_arbiter #(.MASTERS(M)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .trans      (trans),
    .burst      (burst),
    .ready      (ready),
`ifdef AHB_ARB_LOCK_EN
    .lock       (lock),
`endif
    .grant      (grant),
    .addr_owner (addr_owner),
    .data_owner (data_owner),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the bus and how much of the current transfer remains.
  int m_owner, m_downer;
  bit m_dvalid;
  bit in_fixed, in_undef;
  int beats_left;

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd0: return 1;
      3'd1: return 0;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int next_rr(input int own, input logic [3:0] r);
    for (int d = 1; d <= M; d++) begin
      if (r[(own + d) % M]) return (own + d) % M;
    end
    return own;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_downer = 0; m_dvalid = 0;
    in_fixed = 0; in_undef = 0; beats_left = 0;
  endtask

  task automatic start_burst();
    int len;
    len        = burst_len(burst);
    in_undef   = (len == 0);
    in_fixed   = (len > 1);
    beats_left = (len > 1) ? len - 1 : 0;
  endtask

  task automatic model_edge();
    bit handover;
    bit locked;
    handover = 0;
    if (!ready) return;
    m_downer = m_owner;
    m_dvalid = (trans == 2'd2) || (trans == 2'd3);
    if (in_fixed) begin
      if (trans == 2'd3) begin
        beats_left--;
        if (beats_left == 0) begin
          in_fixed = 0;
          handover = 1;
        end
      end else if (trans == 2'd2) begin
        start_burst();
      end
    end else if (in_undef) begin
      if (trans == 2'd0 || (trans == 2'd2 && !req[m_owner])) begin
        in_undef = 0;
        handover = 1;
      end else if (trans == 2'd2) begin
        start_burst();
      end
    end else begin
      if (trans == 2'd0) handover = 1;
      else if (trans == 2'd2) begin
        if (burst == 3'd0) handover = 1;
        else start_burst();
      end
    end
`ifdef AHB_ARB_LOCK_EN
    locked = lock[m_owner];
`else
    locked = 0;
`endif
    if (handover && !locked) m_owner = next_rr(m_owner, req);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input int ao, input int dow,
                         input bit dv);
    chk({name, ".grant"}, int'(grant), int'(g));
    chk({name, ".addr_owner"}, int'(addr_owner), ao);
    chk({name, ".data_owner"}, int'(data_owner), dow);
    chk({name, ".data_valid"}, int'(data_valid), int'(dv));
  endtask

  task automatic chk_model(input string name);
    logic [3:0] g;
    g = 4'b0001 << m_owner;
    chk_out(name, g, m_owner, m_downer, m_dvalid);
  endtask

  task automatic step(input logic [3:0] r, input logic [1:0] t, input logic [2:0] b,
                      input logic rd);
    req = r; trans = t; burst = b; ready = rd;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] e_grant;
    int         e_owner;
    int         e_downer;
    bit         e_dv;
  } vec_t;

  vec_t vt[$];

  initial begin
    vt.push_back(vec_t'{4'b1111, 2'd2, 3'd0, 1'b1, 4'b0010, 1, 0, 1'b1});
    vt.push_back(vec_t'{4'b1111, 2'd2, 3'd0, 1'b1, 4'b0100, 2, 1, 1'b1});
    vt.push_back(vec_t'{4'b1111, 2'd2, 3'd0, 1'b1, 4'b1000, 3, 2, 1'b1});
    vt.push_back(vec_t'{4'b1111, 2'd2, 3'd0, 1'b1, 4'b0001, 0, 3, 1'b1});
    vt.push_back(vec_t'{4'b0110, 2'd0, 3'd0, 1'b1, 4'b0010, 1, 0, 1'b0});
    vt.push_back(vec_t'{4'b0110, 2'd2, 3'd5, 1'b1, 4'b0010, 1, 1, 1'b1});
    for (int i = 0; i < 3; i++)
      vt.push_back(vec_t'{4'b0110, 2'd3, 3'd5, 1'b1, 4'b0010, 1, 1, 1'b1});
    // Master 1 drops its request mid-burst; the burst must still run to completion.
    for (int i = 0; i < 3; i++)
      vt.push_back(vec_t'{4'b0100, 2'd3, 3'd5, 1'b1, 4'b0010, 1, 1, 1'b1});
    vt.push_back(vec_t'{4'b0100, 2'd3, 3'd5, 1'b1, 4'b0100, 2, 1, 1'b1});
    vt.push_back(vec_t'{4'b0100, 2'd0, 3'd0, 1'b1, 4'b0100, 2, 2, 1'b0});
    vt.push_back(vec_t'{4'b1001, 2'd2, 3'd0, 1'b0, 4'b0100, 2, 2, 1'b0});

    rstn = 1'b0; req = '0; trans = '0; burst = '0; ready = 1'b1; lock = '0;
    model_reset();
    #11;
    chk_out("reset", 4'b0001, 0, 0, 1'b0);
    #1 rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 2'd0, 3'd0, 1'b1);
      chk_out($sformatf("park%0d", i), 4'b0001, 0, 0, 1'b0);
    end

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].req, vt[i].trans, vt[i].burst, vt[i].ready);
      chk_out($sformatf("vec%0d", i), vt[i].e_grant, vt[i].e_owner, vt[i].e_downer, vt[i].e_dv);
    end

    // INCR4 by master 2 with three wait states on beat 2.
    step(4'b1100, 2'd2, 3'd3, 1'b1);
    chk_out("incr4.b1", 4'b0100, 2, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1100, 2'd3, 3'd3, 1'b0);
      chk_out($sformatf("incr4.wait%0d", i), 4'b0100, 2, 2, 1'b1);
    end
    step(4'b1100, 2'd3, 3'd3, 1'b1);
    chk_out("incr4.b2", 4'b0100, 2, 2, 1'b1);
    step(4'b1100, 2'd3, 3'd3, 1'b1);
    chk_out("incr4.b3", 4'b0100, 2, 2, 1'b1);
    step(4'b1100, 2'd3, 3'd3, 1'b1);
    chk_out("incr4.b4", 4'b1000, 3, 2, 1'b1);

    // WRAP16 by master 3, reset pulsed during beat 3.
    step(4'b1000, 2'd2, 3'd6, 1'b1);
    chk_out("wrap16.b1", 4'b1000, 3, 3, 1'b1);
    step(4'b1000, 2'd3, 3'd6, 1'b1);
    chk_out("wrap16.b2", 4'b1000, 3, 3, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk_out("async_reset", 4'b0001, 0, 0, 1'b0);
    #2 rstn = 1'b1;
    model_reset();
    step(4'b1010, 2'd0, 3'd0, 1'b1);
    chk_out("post_reset", 4'b0010, 1, 0, 1'b0);

`ifdef AHB_ARB_LOCK_EN
    step(4'b0100, 2'd0, 3'd0, 1'b1);
    chk_out("lock.get", 4'b0100, 2, 1, 1'b0);
    lock = 4'b0100;
    step(4'b0101, 2'd2, 3'd0, 1'b1);
    chk_out("lock.s1", 4'b0100, 2, 2, 1'b1);
    step(4'b0101, 2'd2, 3'd0, 1'b1);
    chk_out("lock.s2", 4'b0100, 2, 2, 1'b1);
    lock = 4'b0000;
    step(4'b0101, 2'd0, 3'd0, 1'b1);
    chk_out("lock.rel", 4'b0001, 0, 2, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] t;
      int w;
      w = $urandom_range(0, 9);
      if (w < 2) t = 2'd0;
      else if (w < 3) t = 2'd1;
      else if (w < 6) t = 2'd2;
      else t = 2'd3;
`ifdef AHB_ARB_LOCK_EN
      lock = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
`endif
      step(4'($urandom), t, 3'($urandom), ($urandom_range(0, 3) != 0));
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
